// File: rtl/vga_pkg.sv
// Shared VGA timing constants, FSM state type and bounding-box record for the
// target tracker.
package vga_pkg;
  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t H_ACT_START = 11'd154;
  localparam cnt_t H_ACT_END   = 11'd784;
  localparam cnt_t V_ACT_START = 11'd35;
  localparam cnt_t V_ACT_END   = 11'd515;

  typedef enum logic [1:0] {IDLE, ARM, SCAN, COMMIT} state_e;

  typedef struct packed {
    cnt_t h_min;
    cnt_t h_max;
    cnt_t v_min;
    cnt_t v_max;
  } bbox_t;

  function automatic logic in_win(input cnt_t h, input cnt_t v);
    return (h >= H_ACT_START) && (h <= H_ACT_END) &&
           (v >= V_ACT_START) && (v <= V_ACT_END);
  endfunction
endpackage

// File: rtl/box_track_ctrl_if.sv
// Pixel-stream inputs and tracker outputs between the VGA timing path and the
// box tracker.
interface box_track_ctrl_if;
  import vga_pkg::*;
  cnt_t        hsync_cnt;
  cnt_t        vsync_cnt;
  logic [7:0]  binary;
  logic        box;
  logic        box_valid;
  cnt_t        box_h_min;
  cnt_t        box_h_max;
  cnt_t        box_v_min;
  cnt_t        box_v_max;
  logic        frame_done;

  modport master (
    output hsync_cnt, vsync_cnt, binary,
    input  box, box_valid, box_h_min, box_h_max, box_v_min, box_v_max, frame_done
  );
  modport slave (
    input  hsync_cnt, vsync_cnt, binary,
    output box, box_valid, box_h_min, box_h_max, box_v_min, box_v_max, frame_done
  );
endinterface

// File: rtl/box_ring_gen.sv
// Combinational overlay ring: grows the published box by MARGIN (clamped to the
// counter range) and flags pixels inside a BORDER-thick inclusive frame.
module box_ring_gen
  import vga_pkg::*;
#(
  parameter int MARGIN = 4,
  parameter int BORDER = 2
) (
  input  logic  valid,
  input  bbox_t bb,
  input  cnt_t  h,
  input  cnt_t  v,
  output logic  box_next
);
  // One extra bit so +MARGIN/+BORDER never wrap before the clamp.
  localparam int XW = CNT_W + 1;
  typedef logic [XW-1:0] ext_t;
  localparam ext_t MAX_C = ext_t'({CNT_W{1'b1}});
  localparam ext_t M_X   = ext_t'(MARGIN);
  localparam ext_t B_X   = ext_t'(BORDER);

  ext_t l, r, t, b, h_x, v_x, r_sum, b_sum;
  logic in_rect, on_edge;

  always_comb begin
    h_x     = {1'b0, h};
    v_x     = {1'b0, v};
    l       = ({1'b0, bb.h_min} >= M_X) ? {1'b0, bb.h_min} - M_X : '0;
    t       = ({1'b0, bb.v_min} >= M_X) ? {1'b0, bb.v_min} - M_X : '0;
    r_sum   = {1'b0, bb.h_max} + M_X;
    b_sum   = {1'b0, bb.v_max} + M_X;
    r       = (r_sum > MAX_C) ? MAX_C : r_sum;
    b       = (b_sum > MAX_C) ? MAX_C : b_sum;
    in_rect = (h_x >= l) && (h_x <= r) && (v_x >= t) && (v_x <= b);
    // h > R-BORDER rewritten as h+BORDER > R so a small R cannot underflow.
    on_edge = (h_x < l + B_X) || (h_x + B_X > r) ||
              (v_x < t + B_X) || (v_x + B_X > b);
    box_next = valid && in_rect && on_edge;
  end
endmodule

// File: rtl/box_track_ctrl.sv
// Per-frame bounding-box tracker with lost-target hysteresis and a registered
// overlay strobe for the display mux.
module box_track_ctrl
  import vga_pkg::*;
#(
  parameter int MIN_PIX     = 16,
  parameter int LOST_FRAMES = 4,
  parameter int MARGIN      = 4,
  parameter int BORDER      = 2
) (
  input  logic            clk_24m,
  input  logic            rst,
  box_track_ctrl_if.slave bus
);
  localparam int MW = $clog2(LOST_FRAMES + 1);
  localparam logic [MW-1:0] LOST_M = MW'(LOST_FRAMES);
  localparam bbox_t ACC_INIT = '{h_min: '1, h_max: '0, v_min: '1, v_max: '0};

  state_e        state_q, state_d;
  bbox_t         acc_q, acc_d, pub_q, pub_d;
  logic [15:0]   pix_cnt_q, pix_cnt_d;
  logic [MW-1:0] miss_cnt_q, miss_cnt_d;
  logic          valid_q, valid_d;
  logic          box_q, box_next;
  logic          frame_done;
  logic          tgt;
  cnt_t          h, v;

  assign h   = bus.hsync_cnt;
  assign v   = bus.vsync_cnt;
  assign tgt = in_win(h, v) && !bus.binary[7];

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    pub_d      = pub_q;
    pix_cnt_d  = pix_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = valid_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: state_d = ARM;
      ARM: begin
        acc_d     = ACC_INIT;
        pix_cnt_d = '0;
        // Wait for the blanking lines so a partial frame is never committed.
        if (v < V_ACT_START) state_d = SCAN;
      end
      SCAN: begin
        if (v > V_ACT_END) begin
          state_d = COMMIT;
        end else if (tgt) begin
          if (pix_cnt_q != 16'hFFFF) pix_cnt_d = pix_cnt_q + 16'd1;
          if (h < acc_q.h_min) acc_d.h_min = h;
          if (h > acc_q.h_max) acc_d.h_max = h;
          if (v < acc_q.v_min) acc_d.v_min = v;
          if (v > acc_q.v_max) acc_d.v_max = v;
        end
      end
      COMMIT: begin
        frame_done = 1'b1;
        state_d    = ARM;
        if (pix_cnt_q >= 16'(MIN_PIX)) begin
          pub_d      = acc_q;
          miss_cnt_d = '0;
          valid_d    = 1'b1;
        end else begin
          miss_cnt_d = (miss_cnt_q >= LOST_M) ? LOST_M : miss_cnt_q + MW'(1);
          if (miss_cnt_d == LOST_M) valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_24m) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= ACC_INIT;
      pub_q      <= '0;
      pix_cnt_q  <= '0;
      miss_cnt_q <= LOST_M;
      valid_q    <= 1'b0;
      box_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      pub_q      <= pub_d;
      pix_cnt_q  <= pix_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
      box_q      <= box_next;
    end
  end

  box_ring_gen #(.MARGIN(MARGIN), .BORDER(BORDER)) u_ring (
    .valid    (valid_q),
    .bb       (pub_q),
    .h        (h),
    .v        (v),
    .box_next (box_next)
  );

  assign bus.box        = box_q;
  assign bus.box_valid  = valid_q;
  assign bus.box_h_min  = pub_q.h_min;
  assign bus.box_h_max  = pub_q.h_max;
  assign bus.box_v_min  = pub_q.v_min;
  assign bus.box_v_max  = pub_q.v_max;
  assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_box_track_ctrl.sv
// Scoreboard bench for box_track_ctrl: compressed frames drive only the pixels
// of interest; commits and overlay probes are checked by one monitor process.
module tb_box_track_ctrl;
  typedef struct { int h; int v; logic e; } probe_t;

  logic clk_24m = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_24m = ~clk_24m;

  box_track_ctrl_if bus ();

  box_track_ctrl dut (
    .clk_24m (clk_24m),
    .rst     (rst),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  logic probe = 1'b0, probe_arm = 1'b0, rst_chk = 1'b0, done = 1'b0;
  probe_t      exp_box_q[$];
  logic [44:0] exp_cmt_q[$];

  function automatic logic [44:0] pk(input logic vld, input int a, input int b,
                                     input int c, input int d);
    return {vld, 11'(a), 11'(b), 11'(c), 11'(d)};
  endfunction

  task automatic cyc(input int h, input int v, input logic tgt,
                     input logic pr = 1'b0, input logic ex = 1'b0);
    probe_t p;
    @(posedge clk_24m); #1;
    rst           = 1'b0;
    rst_chk       = 1'b0;
    bus.hsync_cnt = 11'(h);
    bus.vsync_cnt = 11'(v);
    bus.binary    = tgt ? 8'h00 : 8'hFF;
    probe         = pr;
    if (pr) begin
      p.h = h; p.v = v; p.e = ex;
      exp_box_q.push_back(p);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_24m); #1;
    rst = 1'b1; probe = 1'b0;
    @(posedge clk_24m); #1;
    rst_chk = 1'b1;
  endtask

  task automatic pr(input int h, input int v, input logic e);
    cyc(h, v, 1'b0, 1'b1, e);
  endtask

  task automatic frame_start();
    cyc(0, 0, 1'b0);
    cyc(0, 0, 1'b0);
  endtask

  task automatic frame_end(input logic [44:0] exp);
    exp_cmt_q.push_back(exp);
    repeat (3) cyc(0, 516, 1'b0);
  endtask

  task automatic block(input int h0, input int w, input int v0, input int ht);
    for (int vv = v0; vv < v0 + ht; vv++)
      for (int hh = h0; hh < h0 + w; hh++)
        cyc(hh, vv, 1'b1);
  endtask

  always @(posedge clk_24m) probe_arm <= probe;

  // Monitor: the only process that compares and counts.
  initial begin
    logic        cmt_pend;
    logic [44:0] act, ex;
    probe_t      p;
    cmt_pend = 1'b0;
    forever begin
      @(negedge clk_24m);
      if (done) break;
      act = {bus.box_valid, bus.box_h_min, bus.box_h_max, bus.box_v_min, bus.box_v_max};
      if (cmt_pend) begin
        cmt_pend = 1'b0;
        ex = exp_cmt_q.pop_front();
        checks++;
        if (act !== ex) begin
          errors++;
          $display("FAIL commit: got v=%0b h=%0d..%0d v=%0d..%0d, want v=%0b h=%0d..%0d v=%0d..%0d",
                   act[44], act[43:33], act[32:22], act[21:11], act[10:0],
                   ex[44], ex[43:33], ex[32:22], ex[21:11], ex[10:0]);
        end
      end
      if (bus.frame_done === 1'b1) begin
        if (exp_cmt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_done: unexpected pulse at t=%0t, want none", $time);
        end else begin
          cmt_pend = 1'b1;
        end
      end
      if (probe_arm && exp_box_q.size() != 0) begin
        p = exp_box_q.pop_front();
        checks++;
        if (bus.box !== p.e) begin
          errors++;
          $display("FAIL box(%0d,%0d): got %b want %b", p.h, p.v, bus.box, p.e);
        end
      end
      if (rst_chk) begin
        checks++;
        if ({act, bus.box, bus.frame_done} !== 47'd0) begin
          errors++;
          $display("FAIL reset_outputs: got %h want 0", {act, bus.box, bus.frame_done});
        end
      end
    end
    checks++;
    if (exp_cmt_q.size() != 0 || exp_box_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d commits and %0d probes never seen, want 0",
               exp_cmt_q.size(), exp_box_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.hsync_cnt = '0;
    bus.vsync_cnt = '0;
    bus.binary    = 8'hFF;
    do_reset();

    // Empty frame: miss, box never drawn.
    frame_start();
    pr(300, 100, 1'b0); pr(296, 96, 1'b0);
    frame_end(pk(0, 0, 0, 0, 0));

    // 10x10 block -> hit.
    frame_start();
    block(300, 10, 100, 10);
    frame_end(pk(1, 300, 309, 100, 109));

    // Ring L=296 R=313 T=96 B=113; empty frame = miss 1.
    frame_start();
    pr(296, 96, 1'b1);  pr(297, 113, 1'b1); pr(296, 113, 1'b1);
    pr(298, 100, 1'b0); pr(304, 104, 1'b0); pr(313, 100, 1'b1);
    pr(312, 100, 1'b1); pr(314, 100, 1'b0); pr(300, 95, 1'b0);
    pr(300, 96, 1'b1);  pr(300, 98, 1'b0);  pr(295, 100, 1'b0);
    frame_end(pk(1, 300, 309, 100, 109));
    // Misses 2, 3 hold; miss 4 drops.
    frame_start(); frame_end(pk(1, 300, 309, 100, 109));
    frame_start(); frame_end(pk(1, 300, 309, 100, 109));
    frame_start(); frame_end(pk(0, 300, 309, 100, 109));

    // 15 pixels: miss, box gone; 16 pixels: hit.
    frame_start();
    pr(296, 96, 1'b0);
    block(500, 15, 200, 1);
    frame_end(pk(0, 300, 309, 100, 109));
    frame_start();
    block(500, 16, 200, 1);
    frame_end(pk(1, 500, 515, 200, 200));

    // Ring L=496 R=519 T=196 B=204; window-edge target with strays.
    frame_start();
    pr(496, 200, 1'b1); pr(500, 200, 1'b0); pr(519, 204, 1'b1); pr(520, 200, 1'b0);
    block(154, 4, 35, 4);
    cyc(153, 36, 1'b1);
    exp_cmt_q.push_back(pk(1, 154, 157, 35, 38));
    cyc(200, 516, 1'b1);
    cyc(0, 516, 1'b0); cyc(0, 516, 1'b0);

    // Ring L=150 R=161 T=31 B=42.
    frame_start();
    pr(150, 31, 1'b1); pr(149, 31, 1'b0); pr(150, 30, 1'b0);
    pr(155, 37, 1'b0); pr(161, 42, 1'b1); pr(151, 40, 1'b1);
    frame_end(pk(1, 154, 157, 35, 38));

    // Reset mid-scan: frame discarded, outputs cleared.
    frame_start();
    block(400, 20, 300, 1);
    do_reset();
    // No v<35 pass yet: these targets and the v=516 lines must not commit.
    block(400, 20, 100, 1);
    pr(396, 96, 1'b0);
    repeat (3) cyc(0, 516, 1'b0);
    frame_start();
    block(600, 16, 400, 1);
    frame_end(pk(1, 600, 615, 400, 400));
    frame_start();
    pr(596, 396, 1'b1); pr(600, 400, 1'b0);
    frame_end(pk(1, 600, 615, 400, 400));

    repeat (5) cyc(0, 516, 1'b0);
    done = 1'b1;
  end
endmodule

// File: doc/box_track_ctrl.md
Name: box_track_ctrl

Overview:
Per-frame target tracker and overlay scheduler for the VGA pipeline. Scans each frame's active window for target pixels (binary[7]==0) and accumulates a bounding box of min/max h and v. At frame end it commits the result and manages lost-target hysteresis. It drives a registered box overlay strobe into the display mux, replacing the fixed-size first-hit marker.

Parameters:
H_ACT_START, 154, first active hsync_cnt (inclusive)
H_ACT_END, 784, last active hsync_cnt (inclusive)
V_ACT_START, 35, first active vsync_cnt (inclusive)
V_ACT_END, 515, last active vsync_cnt (inclusive)
MIN_PIX, 16, minimum target pixel count for a frame to count as a hit
LOST_FRAMES, 4, consecutive miss frames before the box is dropped
MARGIN, 4, pixels added around the bounding box on each side
BORDER, 2, overlay line thickness in pixels

Ports:
clk_24m  in  1  pixel clock
rst  in  1  synchronous reset, active-high
hsync_cnt  in  11  horizontal pixel counter
vsync_cnt  in  11  vertical line counter
binary  in  8  pixel class; bit 7 low = target pixel
box  out  1  registered overlay strobe for the current pixel
box_valid  out  1  tracker holds a valid box
box_h_min, box_h_max, box_v_min, box_v_max  out  11 each  committed bounding box, margin not applied
frame_done  out  1  one-cycle pulse on commit

Behaviour:
- Reset state: IDLE. All outputs 0. Accumulators cleared. miss_cnt = LOST_FRAMES, so the tracker starts lost.
- in_win = H_ACT_START<=h<=H_ACT_END and V_ACT_START<=v<=V_ACT_END. Comparisons are unsigned 11-bit.
- FSM:
  - IDLE -> ARM next cycle.
  - ARM: accumulators held at init: acc_hmin=acc_vmin=11'h7FF, acc_hmax=acc_vmax=0, pix_cnt=0. Go to SCAN when v<V_ACT_START. This guarantees a full frame is scanned even if reset was released mid-frame.
  - SCAN: on each cycle with in_win and !binary[7]:
    - pix_cnt+1, 16-bit, saturating at 16'hFFFF.
    - Update acc min/max with h and v.
    - Leave to COMMIT on the first cycle with v>V_ACT_END.
  - COMMIT (exactly 1 cycle): frame_done=1. Then return to ARM.
    - Hit (pix_cnt>=MIN_PIX): publish acc_* to box_* registers, miss_cnt=0, box_valid=1.
    - Miss: box_* unchanged, miss_cnt=min(miss_cnt+1, LOST_FRAMES); box_valid=0 if the new miss_cnt==LOST_FRAMES, else unchanged.
- Published box_* and box_valid change only in the COMMIT cycle and are visible the cycle after. They are stable during active video.
- Overlay geometry, computed from published regs:
  - L = box_h_min-MARGIN, saturating at 0.
  - R = box_h_max+MARGIN, saturating at 2047.
  - T and B derived the same way from box_v_min/box_v_max.
- Overlay strobe: box_next = box_valid and L<=h<=R and T<=v<=B and (h<L+BORDER or h>R-BORDER or v<T+BORDER or v>B-BORDER). The ring is inclusive. box is box_next registered: 1-cycle latency relative to hsync_cnt/vsync_cnt.
- Single-pixel target (min==max): the box is still drawn as a (2*MARGIN+1)-square ring.
- Target pixel at window edge, e.g. h=154 or h=784: included. Pixels outside the window are never counted.
- rst asserted in any state: the next cycle is IDLE with reset values. An in-flight frame is discarded with no frame_done.
- vsync_cnt jumping backwards during SCAN, without ever exceeding V_ACT_END: stay in SCAN. The frame ends only via v>V_ACT_END.

Decomposition:
- Shared package vga_pkg:
  - Active-window constants (154/784/35/515).
  - Counter width (11).
  - FSM state typedef {IDLE, ARM, SCAN, COMMIT}.
- One sub-module, box_ring_gen: combinational margin clamp plus ring compare from the published coordinates, MARGIN and BORDER. The registered strobe lives in the parent.

Test Plan:
1. Reset, then one frame with no target pixels -> frame_done pulses once after v=516; box_valid=0; box never asserted.
2. 10x10 target block at h=300..309, v=100..109 (100 px) -> commit gives h_min=300, h_max=309, v_min=100, v_max=109, box_valid=1. Next frame: box=1 at (h=296..297, v=96..113) one cycle late; box=0 at (h=304, v=104).
3. Hit frame, then 3 empty frames -> box_valid stays 1 with coordinates held. A 4th empty frame -> box_valid=0 after that commit.
4. Only 15 target pixels in a frame (MIN_PIX=16) -> miss path taken; coordinates unchanged; a 16-pixel frame -> hit.
5. Target at h=154, v=35 plus stray pixels at h=153 and v=516 -> h_min=154, v_min=35; strays ignored. L/T clamp to 150/31, no wrap.
6. Assert rst at v=300 mid-SCAN with targets present -> no frame_done, outputs 0. The first commit after release occurs only after the next v<35 pass.
